// File: rtl/nwc_input_loader.sv
// nwc_input_loader: packs a coefficient stream of two polynomials into
// double-width NWC processor words, then sequences start and result wait.
module nwc_input_loader #(
  parameter int LOG_N       = 12,
  parameter int COEFF_WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [COEFF_WIDTH-1:0]   s_coeff_a,
  input  logic [COEFF_WIDTH-1:0]   s_coeff_b,
  output logic [2*COEFF_WIDTH-1:0] data_in0,
  output logic [2*COEFF_WIDTH-1:0] data_in1,
  output logic                     write_enable,
  output logic                     start,
  input  logic                     output_active,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  localparam logic [LOG_N-1:0] LAST = '1;

  state_t                 state;
  logic [LOG_N-1:0]       cnt;
  logic [COEFF_WIDTH-1:0] lo_a;
  logic [COEFF_WIDTH-1:0] lo_b;
  logic                   accept;

  assign accept = s_valid & s_ready;

  // done marks the cycle the result stream drops while waiting for it
  assign done = (state == WAIT_LO) && !output_active;

  // load, pack, start and wait sequencing with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      cnt          <= '0;
      lo_a         <= '0;
      lo_b         <= '0;
      s_ready      <= 1'b0;
      write_enable <= 1'b0;
      start        <= 1'b0;
      busy         <= 1'b0;
      data_in0     <= '0;
      data_in1     <= '0;
    end else begin
      write_enable <= 1'b0;
      start        <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == '0) begin
              busy <= 1'b1;
            end
            if (!cnt[0]) begin
              lo_a <= s_coeff_a;
              lo_b <= s_coeff_b;
            end else begin
              write_enable <= 1'b1;
              data_in0     <= {s_coeff_a, lo_a};
              data_in1     <= {s_coeff_b, lo_b};
            end
            if (cnt == LAST) begin
              state   <= START;
              s_ready <= 1'b0;
            end else begin
              s_ready <= 1'b1;
            end
          end else begin
            s_ready <= 1'b1;
          end
        end
        START: begin
          start <= 1'b1;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (output_active) begin
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!output_active) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nwc_input_loader.sv
// tb_nwc_input_loader: stream driver, word-level scoreboard and
// handshake vector table for nwc_input_loader.
module tb_nwc_input_loader;

  localparam int LOG_N = 12;
  localparam int CW    = 30;
  localparam int NB    = 1 << LOG_N;
  localparam int NW    = NB / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [CW-1:0] s_coeff_a;
  logic [CW-1:0] s_coeff_b;
  logic [2*CW-1:0] data_in0;
  logic [2*CW-1:0] data_in1;
  logic          write_enable;
  logic          start;
  logic          output_active;
  logic          busy;
  logic          done;

  nwc_input_loader #(.LOG_N(LOG_N), .COEFF_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_coeff_a(s_coeff_a), .s_coeff_b(s_coeff_b),
    .data_in0(data_in0), .data_in1(data_in1),
    .write_enable(write_enable), .start(start),
    .output_active(output_active),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] ma [NB];
  logic [CW-1:0] mb [NB];

  bit   exp_we, exp_start, exp_start_n;
  int   nbeat, wk, writes, starts, dones;
  int   cyc = 0;
  int   done_cyc = 0;
  int   first_we_cyc = -1;
  logic [2*CW-1:0] last0, last1, e0, e1;

  typedef struct {
    logic oa;
    logic done;
    logic rdy;
    logic busy;
  } hs_vec_t;

  hs_vec_t hs_tab [9];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: word k of a pair is {X[2k+1],X[2k]}, written the cycle
  // after its odd beat; start follows the last word by one cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      nbeat = 0; exp_we = 0; exp_start = 0; wk = 0;
      last0 = '0; last1 = '0;
    end else begin
      chk("write_enable", {63'd0, write_enable}, {63'd0, exp_we});
      if (write_enable) begin
        writes++;
        if (first_we_cyc < 0) first_we_cyc = cyc;
        e0 = {ma[2*wk+1], ma[2*wk]};
        e1 = {mb[2*wk+1], mb[2*wk]};
        chk("data_in0", {4'd0, data_in0}, {4'd0, e0});
        chk("data_in1", {4'd0, data_in1}, {4'd0, e1});
        last0 = e0; last1 = e1;
        exp_start_n = (wk == NW - 1);
        wk = (wk + 1) % NW;
      end else begin
        chk("data_in0 hold", {4'd0, data_in0}, {4'd0, last0});
        chk("data_in1 hold", {4'd0, data_in1}, {4'd0, last1});
        exp_start_n = 0;
      end
      chk("start", {63'd0, start}, {63'd0, exp_start});
      if (start) starts++;
      exp_start = exp_start_n;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (s_valid && s_ready) begin
        exp_we = (nbeat % 2) == 1;
        nbeat = (nbeat + 1) % NB;
      end else begin
        exp_we = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(int n, int gap, bit rnd, bit noise);
    bit acc;
    for (int i = 0; i < NB; i++) begin
      ma[i] = rnd ? CW'($urandom) : CW'(i);
      mb[i] = rnd ? CW'($urandom) : CW'(i + 4096);
    end
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap) begin
        s_valid = 1'b0;
        if (noise) output_active = 1'($urandom_range(1));
        tick();
      end
      s_valid   = 1'b1;
      s_coeff_a = ma[i];
      s_coeff_b = mb[i];
      acc = 0;
      for (int t = 0; t < 50 && !acc; t++) begin
        if (noise) output_active = 1'($urandom_range(1));
        @(negedge clk);
        acc = s_ready;
        tick();
      end
      if (!acc) begin
        $display("FAIL s_ready timeout: beat %0d got 0 expected 1", i);
        errors++;
        $fatal(1, "loader stalled");
      end
    end
    s_valid = 1'b0;
    output_active = 1'b0;
  endtask

  task automatic wait_start();
    bit found = 0;
    for (int t = 0; t < 8 && !found; t++) begin
      @(negedge clk);
      found = start;
      tick();
    end
    chk("start seen", {63'd0, found}, 64'd1);
    chk("writes per pair", writes, NW);
    chk("starts per pair", starts, 1);
    chk("no done in load", dones, 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < 9; i++) begin
      output_active = hs_tab[i].oa;
      @(negedge clk);
      chk($sformatf("tab%0d done", i), {63'd0, done}, {63'd0, hs_tab[i].done});
      chk($sformatf("tab%0d s_ready", i), {63'd0, s_ready}, {63'd0, hs_tab[i].rdy});
      chk($sformatf("tab%0d busy", i), {63'd0, busy}, {63'd0, hs_tab[i].busy});
      tick();
    end
    output_active = 1'b0;
  endtask

  task automatic clr_counts();
    writes = 0; starts = 0; dones = 0;
  endtask

  initial begin
    hs_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
    hs_tab[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    hs_tab[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
    hs_tab[3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    hs_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    hs_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b0};
    hs_tab[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
    hs_tab[7] = '{1'b1, 1'b0, 1'b1, 1'b0};
    hs_tab[8] = '{1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; s_valid = 1'b0; output_active = 1'b0;
    s_coeff_a = '0; s_coeff_b = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst write_enable", {63'd0, write_enable}, 64'd0);
    chk("rst start", {63'd0, start}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst data_in0", {4'd0, data_in0}, 64'd0);
    chk("rst data_in1", {4'd0, data_in1}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready before edge", {63'd0, s_ready}, 64'd0);
    tick();
    @(negedge clk);
    chk("s_ready after edge", {63'd0, s_ready}, 64'd1);
    chk("busy idle", {63'd0, busy}, 64'd0);
    tick();

    clr_counts();
    send_beats(NB, 0, 0, 0);
    wait_start();
    output_active = 1'b1;
    for (int t = 0; t < 2048; t++) begin
      @(negedge clk);
      chk("wait s_ready", {63'd0, s_ready}, 64'd0);
      chk("wait done", {63'd0, done}, 64'd0);
      tick();
    end
    output_active = 1'b0;
    @(negedge clk);
    chk("fall done", {63'd0, done}, 64'd1);
    chk("fall s_ready", {63'd0, s_ready}, 64'd0);
    chk("fall busy", {63'd0, busy}, 64'd1);
    tick();
    @(negedge clk);
    chk("post s_ready", {63'd0, s_ready}, 64'd1);
    chk("post done", {63'd0, done}, 64'd0);
    chk("post busy", {63'd0, busy}, 64'd0);
    tick();

    clr_counts();
    send_beats(NB, 50, 1, 0);
    wait_start();
    run_table();

    clr_counts();
    send_beats(NB, 50, 0, 1);
    wait_start();
    output_active = 1'b1;
    repeat (3) tick();
    output_active = 1'b0;
    @(negedge clk);
    chk("b2b done", {63'd0, done}, 64'd1);
    tick();
    first_we_cyc = -1;
    clr_counts();
    send_beats(NB, 0, 1, 0);
    chk("b2b spacing", {63'd0, first_we_cyc > done_cyc}, 64'd1);
    wait_start();
    run_table();

    send_beats(1002, 20, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst s_ready", {63'd0, s_ready}, 64'd0);
    chk("mid rst we", {63'd0, write_enable}, 64'd0);
    chk("mid rst start", {63'd0, start}, 64'd0);
    chk("mid rst busy", {63'd0, busy}, 64'd0);
    chk("mid rst done", {63'd0, done}, 64'd0);
    chk("mid rst data_in0", {4'd0, data_in0}, 64'd0);
    chk("mid rst data_in1", {4'd0, data_in1}, 64'd0);
    tick();
    rst = 1'b0;
    clr_counts();
    send_beats(NB, 10, 1, 0);
    wait_start();
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nwc_input_loader.md
NWC_INPUT_LOADER -- requirements
Module: nwc_input_loader

Interface
REQ-001 SHALL have parameter LOG_N, default 12, meaning log2 of polynomial length (coefficients per polynomial).
REQ-002 SHALL have parameter COEFF_WIDTH, default 30, meaning the bit width of one residue coefficient.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  upstream beat valid.
REQ-006 SHALL have port s_ready  output  1  loader accepts the beat this cycle.
REQ-007 SHALL have port s_coeff_a  input  COEFF_WIDTH  coefficient i of polynomial A.
REQ-008 SHALL have port s_coeff_b  input  COEFF_WIDTH  coefficient i of polynomial B (same index i as A).
REQ-009 SHALL have port data_in0  output  2*COEFF_WIDTH  packed A word to the NWC processor.
REQ-010 SHALL have port data_in1  output  2*COEFF_WIDTH  packed B word to the NWC processor.
REQ-011 SHALL have port write_enable  output  1  data_in0/data_in1 are valid this cycle.
REQ-012 SHALL have port start  output  1  one-cycle NTT start pulse.
REQ-013 SHALL have port output_active  input  1  NWC result-stream active flag from the NWC processor.
REQ-014 SHALL have port busy  output  1  a polynomial pair is loaded or in flight.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the NWC result stream ends.

Function
REQ-016 SHALL be in one of four states: LOAD, START, WAIT_HI, WAIT_LO.
REQ-017 A beat SHALL be accepted only on a rising clk edge with s_valid=1 and s_ready=1.
REQ-018 s_ready SHALL be 1 in LOAD and 0 in all other states.
REQ-019 Beats SHALL arrive in ascending coefficient order i = 0..2^LOG_N-1; beat count is held in a LOG_N-bit counter.
REQ-020 Even-index beats SHALL be held in low-half registers and produce no write.
REQ-021 On acceptance of odd-index beat i, the next cycle SHALL drive write_enable=1, data_in0={A[i],A[i-1]}, data_in1={B[i],B[i-1]}, with the lower index in bits [COEFF_WIDTH-1:0].
REQ-022 write_enable SHALL be 0 in all other cycles; data_in0/data_in1 SHALL hold their last value when write_enable=0.
REQ-023 Exactly 2^(LOG_N-1) write_enable cycles (2048 by default) SHALL occur per pair.
REQ-024 Acceptance of beat 2^LOG_N-1 SHALL move LOAD->START; the beat counter SHALL wrap to 0.
REQ-025 start SHALL be 1 for exactly the one cycle immediately following the final write_enable cycle, then the state SHALL be WAIT_HI.
REQ-026 WAIT_HI SHALL move to WAIT_LO on the first cycle output_active=1.
REQ-027 WAIT_LO SHALL move to LOAD on the first cycle output_active=0, with done=1 in that same transition cycle.
REQ-028 busy SHALL be 1 from the cycle after beat 0 of a pair is accepted until the cycle after the done pulse.
REQ-029 output_active=1 seen in LOAD or START SHALL be ignored.
REQ-030 With s_valid held low mid-load, the state and counters SHALL hold without limit; no timeout.
REQ-031 The loader SHALL add no latency beyond one register stage between beat acceptance and write_enable.
REQ-032 Throughput: one beat per cycle sustained in LOAD; one pair load plus start takes 2^LOG_N+2 cycles minimum.

Reset
REQ-033 While rst=1: state=LOAD, beat counter=0, s_ready=0, write_enable=0, start=0, busy=0, done=0, data_in0=0, data_in1=0.
REQ-034 s_ready SHALL rise on the first clk edge after rst deasserts.
REQ-035 rst mid-operation SHALL discard any partial pair and the pending start; the downstream write-address counter is realigned by system-level reset, not by this block.

Verification
REQ-036 Stream A[i]=i, B[i]=i+4096 with s_valid always 1 -> word k: data_in0={2k+1,2k}, data_in1={4097+2k,4096+2k}; 2048 write_enable cycles; start exactly once, one cycle after the last write_enable.
REQ-037 Random s_valid gaps (50%) -> identical word sequence as REQ-036; no write_enable for a word until its odd-index beat is accepted.
REQ-038 After start, drive output_active=1 for 2048 cycles then 0 -> s_ready=0 throughout; done=1 in the exact falling-edge transition cycle; s_ready=1 the next cycle.
REQ-039 Assert rst after beat 1001 -> all outputs zero; the next full pair yields exactly 2048 writes and one start.
REQ-040 Pulse output_active during LOAD -> no state change, no done pulse.
REQ-041 Two back-to-back pairs -> second pair's first write occurs no earlier than one cycle after the first pair's done pulse.
